// File: rtl/vdc_slot_arbiter_pkg.sv
// Package vdc_pkg: shared types and constants for the VDC RAM slot arbiter.
//   slot_t     : the RAM slot owner granted for one column
//   SLOT_W     : width of slot_t
//   INT_MARGIN : columns on either side of the line wrap that form the
//                interleave window (en_int)
package vdc_pkg;

  localparam int SLOT_W     = 3;
  localparam int INT_MARGIN = 2;

  typedef enum logic [SLOT_W-1:0] {
    SL_NONE = 3'd0,
    SL_CHAR = 3'd1,
    SL_RFSH = 3'd2,
    SL_SCRN = 3'd3,
    SL_ATTR = 3'd4,
    SL_CPU  = 3'd5
  } slot_t;

endpackage

// File: rtl/vdc_slot_arbiter_if.sv
// Interface vdc_slot_arbiter_if: bundles the column timing, register values,
// request lines and grant/completion outputs of the slot arbiter.
//   master : video timing + requesters (drive strobes, registers, requests)
//   slave  : the arbiter (drives grant, done, done_slot, rfsh_addr, busy)
//
// Handshake: a requester raises its *_req and holds it; the arbiter samples
// the request lines only at the arbitration point (enable && newCol) and
// drives grant on the next cycle. The grant is complete when done pulses for
// one cycle with done_slot equal to that requester's slot; only then may the
// requester drop or re-arm its request. Requests are never latched.
interface vdc_slot_arbiter_if;
  import vdc_pkg::*;

  logic        enable;
  logic        newCol;
  logic        endCol;
  logic [7:0]  col;
  logic [7:0]  reg_ht;
  logic [7:0]  reg_hd;
  logic [3:0]  reg_drr;
  logic        char_req;
  logic        scrn_req;
  logic        attr_req;
  logic        cpu_req;
  slot_t       grant;
  logic        done;
  slot_t       done_slot;
  logic [7:0]  rfsh_addr;
  logic        busy;

  modport master (
    output enable, newCol, endCol, col, reg_ht, reg_hd, reg_drr,
    output char_req, scrn_req, attr_req, cpu_req,
    input  grant, done, done_slot, rfsh_addr, busy
  );

  modport slave (
    input  enable, newCol, endCol, col, reg_ht, reg_hd, reg_drr,
    input  char_req, scrn_req, attr_req, cpu_req,
    output grant, done, done_slot, rfsh_addr, busy
  );

endinterface

// File: rtl/vdc_slot_arbiter_rfsh_ctr.sv
// vdc_rfsh_ctr: 8-bit DRAM refresh row counter, wraps 255 -> 0.
//   clk    : core clock
//   rst_n  : asynchronous active-low clear
//   inc_i  : advance to the next row
//   addr_o : current refresh row
module vdc_rfsh_ctr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_i,
  output logic [7:0] addr_o
);

  logic [7:0] addr_q;
  logic [7:0] addr_d;

  assign addr_d = inc_i ? addr_q + 8'd1 : addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= 8'd0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/vdc_slot_arbiter.sv
// vdc_slot_arbiter: per-column single-port VDC RAM slot scheduler.
// Grants the one RAM slot of each column to CHAR, RFSH, SCRN, ATTR or CPU,
// signals completion and owns the refresh row counter.
//   clk     : core clock
//   reset_n : asynchronous active-low reset
//   bus     : vdc_slot_arbiter_if.slave (strobes, registers, requests in;
//             grant, done, done_slot, rfsh_addr, busy out)
// Parameter STARVE_LIMIT: denied CPU arbitrations before CPU is forced in.
// Optional macro VDC_CPU_STARVE_GUARD_EN enables the CPU starve guard; without
// it the priority order is strict and no starve counter exists.
module vdc_slot_arbiter
  import vdc_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input logic               clk,
  input logic               reset_n,
  vdc_slot_arbiter_if.slave bus
);

  logic       en_int;
  logic       en_rfsh;
  logic [7:0] ht_thr;
  logic [8:0] rfsh_end;
  logic       arb_pt;
  logic       cmp_pt;
  logic       cpu_force;
  slot_t      grant_q, grant_d;
  logic       done_q;
  slot_t      done_slot_q;
  logic       rfsh_inc;

  // 8-bit subtraction wraps on purpose: reg_ht < 2 yields threshold 254/255.
  assign ht_thr   = bus.reg_ht - 8'(INT_MARGIN);
  assign en_int   = (bus.col < 8'(INT_MARGIN)) || (bus.col >= ht_thr);
  // 9-bit sum so a refresh window running past column 255 does not wrap.
  assign rfsh_end = {1'b0, bus.reg_hd} + {5'd0, bus.reg_drr};
  assign en_rfsh  = (bus.col >= bus.reg_hd) && ({1'b0, bus.col} < rfsh_end);

  // endCol wins over a coincident newCol.
  assign cmp_pt = bus.enable && bus.endCol;
  assign arb_pt = bus.enable && bus.newCol && !bus.endCol;

`ifdef VDC_CPU_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (arb_pt) begin
      if (bus.cpu_req && (grant_d != SL_CPU)) begin
        if (starve_q < STARVE_W'(STARVE_LIMIT)) starve_d = starve_q + 1'b1;
      end else begin
        starve_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign cpu_force = bus.cpu_req && (starve_q >= STARVE_W'(STARVE_LIMIT));
`else
  logic [31:0] unused_starve_limit;
  assign unused_starve_limit = 32'(STARVE_LIMIT);
  assign cpu_force = 1'b0;
`endif

  // Winner for this column; only RFSH/SCRN/ATTR are blocked by en_int.
  always_comb begin
    grant_d = SL_NONE;
    if (bus.char_req)                  grant_d = SL_CHAR;
    else if (cpu_force)                grant_d = SL_CPU;
    else if (!en_int && en_rfsh)       grant_d = SL_RFSH;
    else if (!en_int && bus.scrn_req)  grant_d = SL_SCRN;
    else if (!en_int && bus.attr_req)  grant_d = SL_ATTR;
    else if (bus.cpu_req)              grant_d = SL_CPU;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_q     <= SL_NONE;
      done_q      <= 1'b0;
      done_slot_q <= SL_NONE;
    end else begin
      done_q <= 1'b0;
      if (cmp_pt) begin
        if (grant_q != SL_NONE) begin
          done_q      <= 1'b1;
          done_slot_q <= grant_q;
        end
      end else if (arb_pt) begin
        grant_q <= grant_d;
      end
    end
  end

  assign rfsh_inc = cmp_pt && (grant_q == SL_RFSH);

  vdc_rfsh_ctr u_rfsh_ctr (
    .clk    (clk),
    .rst_n  (reset_n),
    .inc_i  (rfsh_inc),
    .addr_o (bus.rfsh_addr)
  );

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.done_slot = done_slot_q;
  assign bus.busy      = (grant_q != SL_NONE);

endmodule

// File: tb/tb_vdc_slot_arbiter.sv
// Bench for vdc_slot_arbiter: directed column scenarios plus randomized
// traffic, checked every cycle against a behavioural model of the slot rules.
module tb_vdc_slot_arbiter;
  import vdc_pkg::*;

  localparam int STARVE_LIMIT = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  vdc_slot_arbiter_if bus ();

  vdc_slot_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  // register values currently programmed
  int ht, hd, drr;

  // model state (value the outputs must show after the next edge)
  slot_t m_grant;
  logic  m_done;
  slot_t m_done_slot;
  int    m_rfsh;
  int    m_starve;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_grant     = SL_NONE;
    m_done      = 1'b0;
    m_done_slot = SL_NONE;
    m_rfsh      = 0;
    m_starve    = 0;
  endtask

  // Slot owner chosen from the column rules using plain integer arithmetic.
  function automatic slot_t m_pick(input int c, input bit cr, sr, ar, pr);
    int thr;
    bit in_int, in_rfsh;
    thr     = (ht + 256 - 2) % 256;
    in_int  = (c < 2) || (c >= thr);
    in_rfsh = (c >= hd) && (c < hd + drr);
    if (cr) return SL_CHAR;
`ifdef VDC_CPU_STARVE_GUARD_EN
    if (pr && m_starve >= STARVE_LIMIT) return SL_CPU;
`endif
    if (!in_int && in_rfsh) return SL_RFSH;
    if (!in_int && sr) return SL_SCRN;
    if (!in_int && ar) return SL_ATTR;
    if (pr) return SL_CPU;
    return SL_NONE;
  endfunction

  task automatic compare_all();
    chk("grant",     32'(bus.grant),     32'(m_grant));
    chk("done",      32'(bus.done),      32'(m_done));
    chk("done_slot", 32'(bus.done_slot), 32'(m_done_slot));
    chk("rfsh_addr", 32'(bus.rfsh_addr), 32'(m_rfsh));
    chk("busy",      32'(bus.busy),      32'(m_grant != SL_NONE));
  endtask

  // Drive one cycle of inputs, advance the model, check after the edge.
  task automatic step(input bit en, nc, ec, input int c, input bit cr, sr, ar, pr);
    slot_t p;
    bus.enable   = en;
    bus.newCol   = nc;
    bus.endCol   = ec;
    bus.col      = 8'(c);
    bus.reg_ht   = 8'(ht);
    bus.reg_hd   = 8'(hd);
    bus.reg_drr  = 4'(drr);
    bus.char_req = cr;
    bus.scrn_req = sr;
    bus.attr_req = ar;
    bus.cpu_req  = pr;
    m_done = 1'b0;
    if (en && ec) begin
      if (m_grant != SL_NONE) begin
        m_done      = 1'b1;
        m_done_slot = m_grant;
        if (m_grant == SL_RFSH) m_rfsh = (m_rfsh + 1) % 256;
      end
    end else if (en && nc) begin
      p = m_pick(c, cr, sr, ar, pr);
      if (pr && p != SL_CPU) m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : m_starve;
      else m_starve = 0;
      m_grant = p;
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic arb(input int c, input bit cr, sr, ar, pr);
    step(1, 1, 0, c, cr, sr, ar, pr);
  endtask

  task automatic fin(input int c, input bit cr, sr, ar, pr);
    step(1, 0, 1, c, cr, sr, ar, pr);
  endtask

  initial begin
    bus.enable = 0; bus.newCol = 0; bus.endCol = 0; bus.col = 0;
    bus.reg_ht = 0; bus.reg_hd = 0; bus.reg_drr = 0;
    bus.char_req = 0; bus.scrn_req = 0; bus.attr_req = 0; bus.cpu_req = 0;
    ht = 127; hd = 80; drr = 5;
    model_reset();

    // reset values
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant",     32'(bus.grant),     32'(SL_NONE));
    chk("rst_done",      32'(bus.done),      32'd0);
    chk("rst_done_slot", 32'(bus.done_slot), 32'(SL_NONE));
    chk("rst_rfsh",      32'(bus.rfsh_addr), 32'd0);
    reset_n = 1'b1;

    // one full line with screen/attribute requests held
    for (int c = 0; c < 127; c++) begin
      arb(c, 0, 1, 1, 0);
      if (c >= 80 && c <= 84) chk("line_rfsh", 32'(bus.grant), 32'(SL_RFSH));
      if (c == 85) chk("line_scrn", 32'(bus.grant), 32'(SL_SCRN));
      if (c == 0) chk("line_int_none", 32'(bus.grant), 32'(SL_NONE));
      fin(c, 0, 1, 1, 0);
    end
    chk("line_rfsh_addr", 32'(bus.rfsh_addr), 32'd5);

    // CPU only, inside and outside the interleave window
    arb(0, 0, 0, 0, 1);   chk("cpu_col0", 32'(bus.grant), 32'(SL_CPU));   fin(0, 0, 0, 0, 1);
    arb(126, 0, 0, 0, 1); chk("cpu_col126", 32'(bus.grant), 32'(SL_CPU)); fin(126, 0, 0, 0, 1);
    arb(50, 0, 1, 0, 1);  chk("scrn_over_cpu", 32'(bus.grant), 32'(SL_SCRN)); fin(50, 0, 1, 0, 1);

    // character fetch beats CPU in the interleave window, done one cycle later
    arb(1, 1, 0, 0, 1);
    chk("char_win", 32'(bus.grant), 32'(SL_CHAR));
    fin(1, 1, 0, 0, 1);
    chk("char_done", 32'(bus.done), 32'd1);
    chk("char_done_slot", 32'(bus.done_slot), 32'(SL_CHAR));
    step(1, 0, 0, 2, 0, 0, 0, 0);
    chk("done_pulse_len", 32'(bus.done), 32'd0);

    // reg_ht wrap: ht=0 -> threshold 254, ht=1 -> threshold 255
    ht = 0;
    arb(254, 0, 1, 0, 1); chk("ht0_col254", 32'(bus.grant), 32'(SL_CPU)); fin(254, 0, 1, 0, 1);
    ht = 1;
    arb(255, 0, 1, 0, 1); chk("ht1_col255", 32'(bus.grant), 32'(SL_CPU)); fin(255, 0, 1, 0, 1);
    arb(254, 0, 1, 0, 1); chk("ht1_col254", 32'(bus.grant), 32'(SL_SCRN)); fin(254, 0, 1, 0, 1);
    ht = 127;

    // coincident newCol/endCol: completion only, grant unchanged
    arb(50, 0, 0, 1, 0);
    step(1, 1, 1, 51, 1, 0, 0, 0);
    chk("coinc_grant", 32'(bus.grant), 32'(SL_ATTR));
    chk("coinc_done", 32'(bus.done), 32'd1);

    // reset in the middle of a slot
    arb(85, 0, 1, 0, 0);
    chk("pre_rst_grant", 32'(bus.grant), 32'(SL_SCRN));
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(bus.grant), 32'(SL_NONE));
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_rfsh", 32'(bus.rfsh_addr), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    fin(85, 0, 1, 0, 0);
    chk("post_rst_no_done", 32'(bus.done), 32'd0);

    // 256 refresh slots wrap the row counter back to 0
    for (int i = 1; i <= 256; i++) begin
      arb(80, 0, 0, 0, 0);
      fin(80, 0, 0, 0, 0);
      if (i == 255) chk("rfsh_255", 32'(bus.rfsh_addr), 32'd255);
    end
    chk("rfsh_wrap", 32'(bus.rfsh_addr), 32'd0);

    // screen and CPU held together for ten columns
    for (int i = 1; i <= 10; i++) begin
      arb(50, 0, 1, 0, 1);
`ifdef VDC_CPU_STARVE_GUARD_EN
      chk("starve_seq", 32'(bus.grant), (i == 9) ? 32'(SL_CPU) : 32'(SL_SCRN));
`else
      chk("strict_seq", 32'(bus.grant), 32'(SL_SCRN));
`endif
      fin(50, 0, 1, 0, 1);
    end

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) begin
        ht  = $urandom_range(0, 255);
        hd  = $urandom_range(0, 255);
        drr = $urandom_range(0, 15);
      end
      step($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 255), $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
